// File: rtl/axi_pkg.sv
// Shared AXI4 encodings and the fill-controller state type.
// Contents: burst/size/response encodings, init_state_t.
package axi_pkg;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [2:0] AXI_SIZE_8B     = 3'b011;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        RESP,
        DONE,
        ERR
    } init_state_t;

endpackage

// File: rtl/axi_ram_init_ctrl.sv
// AXI4 write-only master that fills a RAM region with a constant pattern
// using fixed-length INCR bursts, one burst outstanding at a time.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   i_start                start pulse (ignored while o_busy)
//   o_busy                 fill in progress
//   o_init_done/o_init_error  sticky completion status
//   o_aw*/i_awready        write address channel
//   o_w*/i_wready          write data channel
//   i_b*/o_bready          write response channel
module axi_ram_init_ctrl
    import axi_pkg::*;
#(
    parameter int unsigned ID_WIDTH   = 6,
    parameter logic [31:0] MEM_SIZE   = 32'h10000,
    parameter logic [31:0] BASE_ADDR  = 32'h0,
    parameter int unsigned BURST_LEN  = 16,
    parameter logic [63:0] FILL_DATA  = 64'h0,
    parameter bit          AUTO_START = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_start,
    output logic                o_busy,
    output logic                o_init_done,
    output logic                o_init_error,
    output logic [ID_WIDTH-1:0] o_awid,
    output logic [31:0]         o_awaddr,
    output logic [7:0]          o_awlen,
    output logic [2:0]          o_awsize,
    output logic [1:0]          o_awburst,
    output logic                o_awvalid,
    input  logic                i_awready,
    output logic [63:0]         o_wdata,
    output logic [7:0]          o_wstrb,
    output logic                o_wlast,
    output logic                o_wvalid,
    input  logic                i_wready,
    input  logic [ID_WIDTH-1:0] i_bid,
    input  logic [1:0]          i_bresp,
    input  logic                i_bvalid,
    output logic                o_bready
);

    localparam logic [31:0] BurstBytes = 32'(BURST_LEN * 8);
    localparam logic [7:0]  LastBeat   = 8'(BURST_LEN - 1);
    localparam logic [31:0] EndAddr    = BASE_ADDR + MEM_SIZE;

    if (MEM_SIZE == 32'd0) begin : g_bad_size
        $error("axi_ram_init_ctrl: MEM_SIZE must be nonzero");
    end
    if (BURST_LEN < 1 || BURST_LEN > 256) begin : g_bad_len
        $error("axi_ram_init_ctrl: BURST_LEN must be 1..256");
    end
    if ((MEM_SIZE % BurstBytes) != 32'd0 || (BASE_ADDR % BurstBytes) != 32'd0) begin : g_bad_align
        $error("axi_ram_init_ctrl: MEM_SIZE/BASE_ADDR must be burst aligned");
    end

    init_state_t state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [7:0]  beat_q, beat_d;
    logic        auto_q, auto_d;
    logic        trigger;
    logic        resp_ok;

    // auto_q is high only during the first cycle after reset release.
    assign trigger = i_start | (AUTO_START & auto_q);
    assign resp_ok = ((i_bresp == AXI_RESP_OKAY) || (i_bresp == AXI_RESP_EXOKAY)) &&
                     (i_bid == '0);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        beat_d  = beat_q;
        auto_d  = 1'b0;
        unique case (state_q)
            IDLE, DONE, ERR: begin
                if (trigger) begin
                    state_d = ADDR;
                    addr_d  = BASE_ADDR;
                end
            end
            ADDR: begin
                if (i_awready) begin
                    state_d = DATA;
                    beat_d  = 8'd0;
                end
            end
            DATA: begin
                if (i_wready) begin
                    beat_d = beat_q + 8'd1;
                    if (beat_q == LastBeat) begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                if (i_bvalid) begin
                    if (!resp_ok) begin
                        state_d = ERR;
                    end else if (addr_q + BurstBytes == EndAddr) begin
                        state_d = DONE;
                    end else begin
                        addr_d  = addr_q + BurstBytes;
                        state_d = ADDR;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= 32'd0;
            beat_q  <= 8'd0;
            auto_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            beat_q  <= beat_d;
            auto_q  <= auto_d;
        end
    end

    // Outputs decode from registered state only, so payload holds while stalled.
    assign o_busy       = (state_q == ADDR) || (state_q == DATA) || (state_q == RESP);
    assign o_init_done  = (state_q == DONE);
    assign o_init_error = (state_q == ERR);

    assign o_awid    = '0;
    assign o_awaddr  = addr_q;
    assign o_awlen   = LastBeat;
    assign o_awsize  = AXI_SIZE_8B;
    assign o_awburst = AXI_BURST_INCR;
    assign o_awvalid = (state_q == ADDR);

    assign o_wdata  = FILL_DATA;
    assign o_wstrb  = 8'hff;
    assign o_wvalid = (state_q == DATA);
    assign o_wlast  = (state_q == DATA) && (beat_q == LastBeat);

    assign o_bready = (state_q == RESP);

endmodule

// File: tb/tb_axi_ram_init_ctrl.sv
module tb_axi_ram_init_ctrl;
    import axi_pkg::*;

    localparam int unsigned IdW      = 6;
    localparam logic [31:0] MemSize  = 32'h400;
    localparam logic [31:0] BaseAddr = 32'h0;
    localparam int unsigned BurstLen = 16;
    localparam logic [63:0] Fill     = 64'h0;

    logic           clk, rst_n, i_start;
    logic           o_busy, o_init_done, o_init_error;
    logic [IdW-1:0] o_awid;
    logic [31:0]    o_awaddr;
    logic [7:0]     o_awlen;
    logic [2:0]     o_awsize;
    logic [1:0]     o_awburst;
    logic           o_awvalid, i_awready;
    logic [63:0]    o_wdata;
    logic [7:0]     o_wstrb;
    logic           o_wlast, o_wvalid, i_wready;
    logic [IdW-1:0] i_bid;
    logic [1:0]     i_bresp;
    logic           i_bvalid, o_bready;

    axi_ram_init_ctrl #(
        .ID_WIDTH(IdW), .MEM_SIZE(MemSize), .BASE_ADDR(BaseAddr),
        .BURST_LEN(BurstLen), .FILL_DATA(Fill), .AUTO_START(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .o_busy(o_busy),
        .o_init_done(o_init_done), .o_init_error(o_init_error),
        .o_awid(o_awid), .o_awaddr(o_awaddr), .o_awlen(o_awlen), .o_awsize(o_awsize),
        .o_awburst(o_awburst), .o_awvalid(o_awvalid), .i_awready(i_awready),
        .o_wdata(o_wdata), .o_wstrb(o_wstrb), .o_wlast(o_wlast), .o_wvalid(o_wvalid),
        .i_wready(i_wready), .i_bid(i_bid), .i_bresp(i_bresp), .i_bvalid(i_bvalid),
        .o_bready(o_bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard queues: expected AW addresses and expected {wlast, wdata} beats.
    logic [31:0] exp_aw[$];
    logic [64:0] exp_w[$];

    task automatic push_fill(input int nbursts);
        for (int b = 0; b < nbursts; b++) begin
            exp_aw.push_back(BaseAddr + 32'(b * BurstLen * 8));
            for (int i = 0; i < int'(BurstLen); i++) begin
                exp_w.push_back({(i == int'(BurstLen) - 1), Fill});
            end
        end
    endtask

    // Slave model state.
    logic [63:0] ram [0:127];
    bit          stall_en = 0;
    int          err_burst = -1;
    bit          err_bid = 0;
    logic [1:0]  err_resp = AXI_RESP_SLVERR;
    int          b_idx = 0;
    int          aw_count = 0, w_count = 0, b_count = 0;
    bit          aw_open, b_pending, b_first, b_hs, b_bad, aw_hold, w_hold;
    int          b_delay, aw_wait, w_wait, w_beat;
    logic [31:0] cur_addr, hold_addr;
    logic [64:0] hold_w;

    task automatic scrub_ram();
        for (int i = 0; i < 128; i++) ram[i] = 64'hdead_beef_0000_0000 | 64'(i);
    endtask

    // Inputs change only at negedge; a handshake happens at the next posedge
    // when valid and ready are both high after this block runs.
    initial begin
        i_awready = 0; i_wready = 0; i_bvalid = 0; i_bresp = 0; i_bid = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                i_awready = 0; i_wready = 0; i_bvalid = 0;
                aw_open = 0; b_pending = 0; b_first = 0; b_hs = 0;
                aw_hold = 0; w_hold = 0; aw_wait = 0; w_wait = 0; w_beat = 0;
            end else begin
                if (b_hs) begin
                    i_bvalid = 0;
                    b_hs = 0;
                    if (b_bad) begin
                        chk("post_b_error", {o_init_error, o_init_done, o_busy}, 3'b100);
                    end else if (cur_addr + 32'd128 == BaseAddr + MemSize) begin
                        chk("post_b_done", {o_init_done, o_init_error, o_busy}, 3'b100);
                    end else begin
                        chk("post_b_next_aw", {o_awvalid, o_awaddr}, {1'b1, cur_addr + 32'd128});
                    end
                end
                if (aw_hold) chk("aw_stable", {o_awvalid, o_awaddr}, {1'b1, hold_addr});
                if (w_hold) chk("w_stable", {o_wvalid, o_wlast, o_wdata}, {1'b1, hold_w});

                // Write address channel.
                i_awready = !stall_en || aw_wait >= 7 || $urandom_range(0, 2) == 0;
                aw_hold = o_awvalid && !i_awready;
                aw_wait = aw_hold ? aw_wait + 1 : 0;
                hold_addr = o_awaddr;
                if (o_awvalid && i_awready) begin
                    aw_count++;
                    chk("single_outstanding", aw_open, 1'b0);
                    chk("aw_expected", exp_aw.size() != 0, 1'b1);
                    if (exp_aw.size() != 0) begin
                        chk("aw_payload", {o_awid, o_awlen, o_awsize, o_awburst, o_awaddr},
                            {6'd0, 8'(BurstLen - 1), AXI_SIZE_8B, AXI_BURST_INCR,
                             exp_aw.pop_front()});
                    end
                    cur_addr = o_awaddr;
                    aw_open = 1;
                    w_beat = 0;
                end

                // Write response channel (ahead of W so B never precedes wlast).
                if (b_pending && !i_bvalid) begin
                    if (b_first) begin
                        chk("bready_timing", o_bready, 1'b1);
                        b_first = 0;
                    end
                    if (b_delay > 0) begin
                        b_delay--;
                    end else begin
                        b_bad = (b_idx == err_burst);
                        i_bvalid = 1;
                        i_bresp = (b_bad && !err_bid) ? err_resp :
                                  (stall_en ? AXI_RESP_EXOKAY : AXI_RESP_OKAY);
                        i_bid = (b_bad && err_bid) ? 6'd1 : 6'd0;
                    end
                end
                if (i_bvalid && o_bready) begin
                    b_hs = 1;
                    b_pending = 0;
                    b_count++;
                    b_idx++;
                end

                // Write data channel.
                i_wready = !stall_en || w_wait >= 7 || $urandom_range(0, 2) == 0;
                w_hold = o_wvalid && !i_wready;
                w_wait = w_hold ? w_wait + 1 : 0;
                hold_w = {o_wlast, o_wdata};
                if (o_wvalid && i_wready) begin
                    int idx;
                    w_count++;
                    chk("w_after_aw", aw_open, 1'b1);
                    chk("w_expected", exp_w.size() != 0, 1'b1);
                    if (exp_w.size() != 0) begin
                        chk("w_beat", {o_wstrb, o_wlast, o_wdata}, {8'hff, exp_w.pop_front()});
                    end
                    idx = int'((cur_addr - BaseAddr) >> 3) + w_beat;
                    if (idx >= 0 && idx < 128) ram[idx] = o_wdata;
                    w_beat++;
                    if (o_wlast) begin
                        aw_open = 0;
                        b_pending = 1;
                        b_first = 1;
                        b_delay = stall_en ? int'($urandom_range(0, 7)) : 0;
                    end
                end
            end
        end
    end

    task automatic new_test(input int ebur, input bit ebid, input bit stall);
        exp_aw.delete();
        exp_w.delete();
        aw_count = 0; w_count = 0; b_count = 0; b_idx = 0;
        err_burst = ebur; err_bid = ebid; stall_en = stall;
    endtask

    task automatic start_fill();
        @(negedge clk);
        i_start = 1;
        @(negedge clk);
        i_start = 0;
        chk("start_state", {o_awvalid, o_busy, o_init_done, o_init_error}, 4'b1100);
    endtask

    task automatic wait_end(input int budget);
        int n = 0;
        while (!((o_init_done || o_init_error) && !o_busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("completion_timeout", n < budget, 1'b1);
    endtask

    task automatic check_fill_ok(input string tag);
        int dirty = 0;
        chk({tag, "_status"}, {o_init_done, o_init_error, o_busy}, 3'b100);
        chk({tag, "_counts"}, {32'(aw_count), 32'(w_count), 32'(b_count)},
            {32'd8, 32'd128, 32'd8});
        chk({tag, "_queues_empty"}, {32'(exp_aw.size()), 32'(exp_w.size())}, 64'd0);
        for (int i = 0; i < 128; i++) if (ram[i] !== Fill) dirty++;
        chk({tag, "_ram_filled"}, dirty, 0);
    endtask

    initial begin
        rst_n = 0;
        i_start = 0;
        scrub_ram();
        repeat (3) @(negedge clk);
        chk("reset_outputs",
            {o_busy, o_init_done, o_init_error, o_awvalid, o_wvalid, o_wlast, o_bready}, 7'd0);

        // Basic fill via auto-start, with an i_start pulse mid-fill that must be ignored.
        new_test(-1, 0, 0);
        push_fill(8);
        rst_n = 1;
        @(negedge clk);
        chk("auto_first_aw", {o_awvalid, o_busy, o_awaddr}, {2'b11, BaseAddr});
        repeat (40) @(negedge clk);
        i_start = 1;
        @(negedge clk);
        i_start = 0;
        wait_end(2000);
        check_fill_ok("basic");

        // Backpressure on all channels, EXOKAY responses.
        new_test(-1, 0, 1);
        push_fill(8);
        scrub_ram();
        start_fill();
        wait_end(6000);
        check_fill_ok("backpressure");

        // SLVERR on the third burst.
        new_test(2, 0, 0);
        err_resp = AXI_RESP_SLVERR;
        push_fill(3);
        start_fill();
        wait_end(2000);
        chk("slverr_status", {o_init_error, o_init_done, o_busy}, 3'b100);
        repeat (20) @(negedge clk);
        chk("slverr_no_more_aw", {32'(aw_count), 31'd0, o_awvalid}, {32'd3, 32'd0});
        chk("slverr_queues_empty", {32'(exp_aw.size()), 32'(exp_w.size())}, 64'd0);

        // Nonzero BID on the first response.
        new_test(0, 1, 0);
        push_fill(1);
        start_fill();
        wait_end(2000);
        chk("badid_status", {o_init_error, o_init_done, o_busy}, 3'b100);
        repeat (10) @(negedge clk);
        chk("badid_no_more_aw", {32'(aw_count), 31'd0, o_awvalid}, {32'd1, 32'd0});

        // Restart after error completes a full fill.
        new_test(-1, 0, 0);
        push_fill(8);
        scrub_ram();
        start_fill();
        wait_end(2000);
        check_fill_ok("restart");

        // Reset during beat 5 of burst 2, then auto-start refill.
        new_test(-1, 0, 0);
        push_fill(8);
        start_fill();
        begin
            int n = 0;
            @(negedge clk);
            #1;
            while (!(aw_count == 2 && w_beat == 5) && n < 2000) begin
                @(negedge clk);
                #1;
                n++;
            end
            chk("reset_point_reached", n < 2000, 1'b1);
        end
        rst_n = 0;
        #1;
        chk("midreset_outputs",
            {o_busy, o_init_done, o_init_error, o_awvalid, o_wvalid, o_wlast, o_bready}, 7'd0);
        repeat (2) @(negedge clk);
        new_test(-1, 0, 0);
        push_fill(8);
        scrub_ram();
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        chk("midreset_first_aw", {o_awvalid, o_awaddr}, {1'b1, BaseAddr});
        wait_end(2000);
        check_fill_ok("midreset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_ram_init_ctrl.md
Name: axi_ram_init_ctrl

Overview:
AXI4 write-only master that fills the external RAM region with a constant pattern after reset (or on request) using fixed-length INCR bursts. Completion is reported through o_init_done and o_init_error, which drive the core's i_ram_init_done and i_ram_init_error. Sits upstream of the RAM port, muxed with the core's AXI master. The core is held off until o_init_done is high.

Parameters:
ID_WIDTH, 6, width of AWID and BID
MEM_SIZE, 32'h10000, bytes to fill; multiple of BURST_LEN*8
BASE_ADDR, 32'h0, first address; aligned to BURST_LEN*8
BURST_LEN, 16, beats per burst (1..256); BURST_LEN*8 must be at most 4096
FILL_DATA, 64'h0, value written on every beat
AUTO_START, 1, start a fill automatically after reset release

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
i_start  in  1  single-cycle start pulse; ignored while o_busy
o_busy  out  1  fill in progress
o_init_done  out  1  fill completed with no error (sticky)
o_init_error  out  1  fill aborted on a bad response (sticky)
o_awid  out  ID_WIDTH  constant 0
o_awaddr  out  32  burst start address
o_awlen  out  8  BURST_LEN-1
o_awsize  out  3  3'b011 (8 bytes)
o_awburst  out  2  2'b01 (INCR)
o_awvalid  out  1  address valid
i_awready  in  1  address ready
o_wdata  out  64  FILL_DATA
o_wstrb  out  8  8'hff
o_wlast  out  1  last beat of burst
o_wvalid  out  1  write data valid
i_wready  in  1  write data ready
i_bid  in  ID_WIDTH  response ID
i_bresp  in  2  response code
i_bvalid  in  1  response valid
o_bready  out  1  response ready

Behaviour:
- Reset (async assert, sync release): state IDLE; o_awvalid, o_wvalid, o_wlast, o_bready, o_busy, o_init_done, o_init_error all 0; address and beat counters cleared.
- States:
  - IDLE: on trigger, go to ADDR, clear done and error, set addr to BASE_ADDR. Trigger is i_start, or AUTO_START on the first cycle after reset release.
  - ADDR: o_awvalid=1. On awvalid&awready, go to DATA with beat=0.
  - DATA: o_wvalid=1. o_wlast=(beat==BURST_LEN-1). Each wvalid&wready increments beat. On the last-beat handshake, go to RESP.
  - RESP: o_bready=1. On bvalid&bready:
    - If bresp[1]=1 or bid!=0, go to ERR.
    - Else if addr+BURST_LEN*8 == BASE_ADDR+MEM_SIZE, go to DONE.
    - Else addr += BURST_LEN*8 and go to ADDR.
  - DONE: o_init_done=1. i_start returns to ADDR as in IDLE.
  - ERR: o_init_error=1; no further AXI traffic. i_start restarts the fill.
- o_busy=1 in ADDR, DATA and RESP. i_start is ignored while busy.
- Exactly one burst outstanding. W is never issued before its AW handshake.
- Valid/data stability: while awvalid or wvalid is high and ready is low, all payload signals (awaddr, wlast, etc.) hold.
- Timing with an always-ready slave:
  - awvalid rises 1 cycle after the trigger.
  - wvalid rises the cycle after the AW handshake.
  - bready rises the cycle after the wlast handshake.
  - Per burst: 1 + BURST_LEN + (B latency) cycles.
  - o_init_done rises the cycle after the final B handshake.
- Address arithmetic is 32-bit. The end compare uses the full sum; MEM_SIZE=0 is illegal (elaboration assertion).
- bresp EXOKAY (2'b01) is treated as success.
- Reset mid-burst: outputs drop immediately and counters clear. If AUTO_START, the fill restarts from BASE_ADDR after release.

Decomposition:
- Shared package axi_pkg:
  - AXI_BURST_INCR=2'b01
  - AXI_SIZE_8B=3'b011
  - AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR
  - init_state_t enum {IDLE, ADDR, DATA, RESP, DONE, ERR}
- Single module; no sub-module (counters are trivial).

Test Plan:
- Basic fill: MEM_SIZE=0x400, BURST_LEN=16, always-ready slave, OKAY responses -> 8 AWs at 0x000,0x080,…,0x380 with awlen=15; 128 beats of FILL_DATA; wlast on every 16th beat; o_init_done=1 one cycle after the 8th B; RAM model reads 0 everywhere.
- Backpressure: random awready/wready/bvalid stalls up to 7 cycles -> payload stable while valid&!ready, same 8 bursts, done asserted, no extra beats.
- Error: bresp=2'b10 on the 3rd burst (addr 0x100) -> o_init_error=1, o_init_done=0, no AW after 0x100, o_busy=0.
- Bad ID: i_bid=1 on the first response -> ERR, identical to the bresp error case.
- Restart: i_start after the error case -> error cleared, full 8-burst fill, done=1. i_start pulsed mid-fill -> ignored, burst count still 8.
- Reset mid-operation: rst_n low during beat 5 of burst 2 -> all valids 0 combinationally. After release with AUTO_START=1, first AW at 0x000 one cycle later and the fill completes.
